clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-set controller for the 12-hour BCD clock. It sequences write mode: it captures the live time into shadow registers, steps the selected field up or down from debounced button pulses, and commits the result to the time-keeping counter with a one-cycle load strobe. It sits between the button debouncers and the time counter, and drives the edit/field indication used by the LCD formatter.

## Interface
- TIMEOUT_S, default 10: seconds of button inactivity before write mode is abandoned (used only with the timeout feature).
- i_clk  in  1  system clock (12 MHz).
- i_rst_n  in  1  reset; synchronous, active-low.
- i_wr_pulse  in  1  one-cycle pulse that enters or leaves write mode.
- i_sel_inc_pulse / i_sel_dec_pulse  in  1 each  one-cycle pulses that move the field selector.
- i_val_inc_pulse / i_val_dec_pulse  in  1 each  one-cycle pulses that step the selected field.
- i_sec_tick  in  1  one-cycle pulse, once per second.
- i_pm  in  1  live AM/PM flag.
- i_hh / i_mm / i_ss  in  8 each  live time in BCD.
- o_edit  out  1  high while in write mode; the time counter holds while this is high.
- o_field  out  2  selected field: 0=SS, 1=MM, 2=HH, 3=PM.
- o_load  out  1  one-cycle commit strobe.
- o_pm, o_hh, o_ss, o_mm  out  1/8/8/8  shadow time; valid when o_edit or o_load is high.

## Operation
- States:
  - IDLE: not editing.
  - EDIT: shadow registers editable.
  - COMMIT: one cycle, o_load=1.
- IDLE + i_wr_pulse -> EDIT.
  - Shadow regs <= live inputs.
  - o_field <= SS.
- EDIT + i_wr_pulse -> COMMIT -> IDLE.
- EDIT button priority per cycle: wr > sel > val. Only the highest-priority active group acts.
- Field selection:
  - sel_inc steps SS -> MM -> HH -> PM -> SS.
  - sel_dec steps in reverse.
  - sel_inc and sel_dec in the same cycle: no move.
- Value stepping (BCD, wrap-around):
  - SS/MM: 00..59. 59+1 -> 00, 00-1 -> 59.
  - HH: 01..12. 12+1 -> 01, 01-1 -> 12.
  - PM: inc or dec toggles the flag.
  - val_inc and val_dec in the same cycle: no change.
- Stepping a field never carries into another field.
- Out-of-range BCD captured from the live inputs is corrected on the first step: inc -> minimum, dec -> maximum.
- Pulses other than i_wr_pulse are ignored in IDLE.
- Reset (at any time, including mid-edit or during COMMIT):
  - State -> IDLE; no o_load is issued.
  - o_edit=0, o_field=0, o_load=0, o_pm=0, o_hh=8'h12, o_mm=8'h00, o_ss=8'h00.

## Timing
- i_wr_pulse in IDLE at cycle N:
  - o_edit=1 and shadow = live values at cycle N+1.
  - The live value sampled is the one present in cycle N.
- Step or select pulse at cycle N: new o_field / shadow value visible at N+1. Steps are accepted every cycle.
- i_wr_pulse in EDIT at cycle N:
  - o_load=1 at N+1 only, with o_edit still 1.
  - o_edit=0 at N+2.
- Shadow values are stable during the o_load cycle.
- i_wr_pulse during COMMIT is ignored.

## Configuration
- Macro CLOCK_SET_TIMEOUT_EN.
- Defined:
  - A ceil(log2(TIMEOUT_S+1))-bit counter counts i_sec_tick in EDIT.
  - The counter clears on entering EDIT and on any sel or val pulse.
  - When the count reaches TIMEOUT_S, the next cycle -> IDLE: o_edit=0, no o_load, edit discarded.
  - A wr pulse in the same cycle as the timeout takes priority (commit).
- Undefined: no counter is built, i_sec_tick is unused, and EDIT persists indefinitely.

## Structure
- Package clock_pkg holds:
  - Field encodings FLD_SS/FLD_MM/FLD_HH/FLD_PM.
  - State encoding.
  - BCD limit constants 8'h59, 8'h01, 8'h12.
- Sub-module bcd_updown: combinational single-step BCD inc/dec between a min and a max with wrap. Two instances, one for SS/MM limits and one for HH limits.

## Test plan
- Reset, then wr at 10:59:30 PM:
  - o_edit=1 next cycle; o_hh=8'h10, o_mm=8'h59, o_ss=8'h30, o_pm=1, o_field=0.
- In EDIT:
  - sel_inc x1, val_inc -> o_mm=8'h00, o_hh unchanged.
  - sel_inc, val_dec -> o_hh=8'h09.
  - sel_inc, val_inc -> o_pm=0.
- Start at 12:00:00:
  - HH val_inc -> 8'h01; val_dec twice -> 8'h12 then 8'h11.
  - SS val_dec from 00 -> 8'h59.
- Commit:
  - wr in EDIT -> o_load high exactly one cycle carrying the shadow values; o_edit low the cycle after.
  - Simultaneous wr and val_inc -> commit, no step.
- Reset asserted mid-EDIT -> no o_load; all outputs at their reset values next cycle.
- With CLOCK_SET_TIMEOUT_EN and TIMEOUT_S=3:
  - 3 sec ticks without buttons -> o_edit drops, no o_load.
  - A val pulse after 2 ticks restarts the count.

Source files
------------

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the 12-hour BCD clock time-set logic.
//   field_t : editable field selector (SS, MM, HH, PM)
//   state_t : time-set controller states
//   BCD_*   : field limits used by the BCD up/down steppers
// -----------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      FLD_SS = 2'd0,
      FLD_MM = 2'd1,
      FLD_HH = 2'd2,
      FLD_PM = 2'd3
   } field_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [7:0] BCD_ZERO   = 8'h00;
   localparam logic [7:0] BCD_MAX_MS = 8'h59;
   localparam logic [7:0] BCD_MIN_HH = 8'h01;
   localparam logic [7:0] BCD_MAX_HH = 8'h12;

endpackage

// File: rtl/bcd_updown.sv
// -----------------------------------------------------------------------------
// bcd_updown
// Combinational single-step two-digit BCD increment/decrement with wrap
// between min_val and max_val. inc and dec together leave the value alone.
// A value that is not valid BCD or lies outside [min_val, max_val] is forced
// to min_val on inc and to max_val on dec.
// Ports:
//   value   in  8  current BCD value
//   min_val in  8  lowest legal BCD value
//   max_val in  8  highest legal BCD value
//   inc     in  1  step up
//   dec     in  1  step down
//   result  out 8  stepped BCD value
// -----------------------------------------------------------------------------
module bcd_updown (
   input  logic [7:0] value,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] result
);

   logic in_range;

   // Valid BCD digits keep numeric order, so plain compares work on them.
   assign in_range = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                     (value >= min_val) && (value <= max_val);

   always_comb begin
      result = value;
      if (inc && !dec) begin
         if (!in_range || (value == max_val)) begin
            result = min_val;
         end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
         end else begin
            result = {value[7:4], value[3:0] + 4'd1};
         end
      end else if (dec && !inc) begin
         if (!in_range || (value == min_val)) begin
            result = max_val;
         end else if (value[3:0] == 4'd0) begin
            result = {value[7:4] - 4'd1, 4'd9};
         end else begin
            result = {value[7:4], value[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-set controller for the 12-hour BCD clock. A wr pulse copies the live
// time into shadow registers (EDIT); sel pulses pick a field, val pulses step
// it with wrap and no carry; a second wr pulse issues a one-cycle o_load
// (COMMIT) carrying the shadow time, then returns to IDLE.
// Optional feature (macro CLOCK_SET_TIMEOUT_EN): abandon EDIT without loading
// after TIMEOUT_S seconds with no sel/val activity.
// Ports:
//   i_clk, i_rst_n                   clock, synchronous active-low reset
//   i_wr_pulse                       enter / commit write mode
//   i_sel_inc_pulse, i_sel_dec_pulse move field selector
//   i_val_inc_pulse, i_val_dec_pulse step selected field
//   i_sec_tick                       1 Hz pulse (timeout only)
//   i_pm, i_hh, i_mm, i_ss           live time (BCD)
//   o_edit                           high in EDIT and COMMIT
//   o_field                          selected field (0=SS 1=MM 2=HH 3=PM)
//   o_load                           one-cycle commit strobe
//   o_pm, o_hh, o_mm, o_ss           shadow time
// -----------------------------------------------------------------------------
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_S = 10
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr_pulse,
   input  logic       i_sel_inc_pulse,
   input  logic       i_sel_dec_pulse,
   input  logic       i_val_inc_pulse,
   input  logic       i_val_dec_pulse,
   input  logic       i_sec_tick,
   input  logic       i_pm,
   input  logic [7:0] i_hh,
   input  logic [7:0] i_mm,
   input  logic [7:0] i_ss,
   output logic       o_edit,
   output logic [1:0] o_field,
   output logic       o_load,
   output logic       o_pm,
   output logic [7:0] o_hh,
   output logic [7:0] o_ss,
   output logic [7:0] o_mm
);

   state_t     state_reg, state_next;
   field_t     field_reg, field_next;
   logic       pm_reg, pm_next;
   logic [7:0] hh_reg, hh_next;
   logic [7:0] mm_reg, mm_next;
   logic [7:0] ss_reg, ss_next;
   logic [7:0] ms_stepped, hh_stepped;
   logic       timeout;
   logic       sel_any, val_any;

   assign sel_any = i_sel_inc_pulse | i_sel_dec_pulse;
   assign val_any = i_val_inc_pulse | i_val_dec_pulse;

   // SS and MM share limits, so one stepper serves whichever is selected.
   bcd_updown u_step_ms (
      .value   ((field_reg == FLD_MM) ? mm_reg : ss_reg),
      .min_val (BCD_ZERO),
      .max_val (BCD_MAX_MS),
      .inc     (i_val_inc_pulse),
      .dec     (i_val_dec_pulse),
      .result  (ms_stepped)
   );

   bcd_updown u_step_hh (
      .value   (hh_reg),
      .min_val (BCD_MIN_HH),
      .max_val (BCD_MAX_HH),
      .inc     (i_val_inc_pulse),
      .dec     (i_val_dec_pulse),
      .result  (hh_stepped)
   );

`ifdef CLOCK_SET_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_S + 1);
   logic [CNT_W-1:0] idle_cnt_reg;

   // Held at zero outside EDIT, so entering EDIT always starts from zero.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         idle_cnt_reg <= '0;
      end else if ((state_reg != ST_EDIT) || sel_any || val_any) begin
         idle_cnt_reg <= '0;
      end else if (i_sec_tick && (idle_cnt_reg != CNT_W'(TIMEOUT_S))) begin
         idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
   end

   assign timeout = (state_reg == ST_EDIT) && (idle_cnt_reg == CNT_W'(TIMEOUT_S));
`else
   logic        unused_sec_tick;
   logic [31:0] unused_timeout_s;
   assign unused_sec_tick  = i_sec_tick;
   assign unused_timeout_s = TIMEOUT_S;
   assign timeout          = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
         field_reg <= FLD_SS;
         pm_reg    <= 1'b0;
         hh_reg    <= BCD_MAX_HH;
         mm_reg    <= BCD_ZERO;
         ss_reg    <= BCD_ZERO;
      end else begin
         state_reg <= state_next;
         field_reg <= field_next;
         pm_reg    <= pm_next;
         hh_reg    <= hh_next;
         mm_reg    <= mm_next;
         ss_reg    <= ss_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      field_next = field_reg;
      pm_next    = pm_reg;
      hh_next    = hh_reg;
      mm_next    = mm_reg;
      ss_next    = ss_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_wr_pulse) begin
               state_next = ST_EDIT;
               field_next = FLD_SS;
               pm_next    = i_pm;
               hh_next    = i_hh;
               mm_next    = i_mm;
               ss_next    = i_ss;
            end
         end
         ST_EDIT: begin
            // Only the highest-priority active button group acts.
            if (i_wr_pulse) begin
               state_next = ST_COMMIT;
            end else if (timeout) begin
               state_next = ST_IDLE;
            end else if (sel_any) begin
               if (i_sel_inc_pulse && !i_sel_dec_pulse) begin
                  field_next = field_t'(field_reg + 2'd1);
               end else if (i_sel_dec_pulse && !i_sel_inc_pulse) begin
                  field_next = field_t'(field_reg - 2'd1);
               end
            end else if (val_any) begin
               case (field_reg)
                  FLD_SS:  ss_next = ms_stepped;
                  FLD_MM:  mm_next = ms_stepped;
                  FLD_HH:  hh_next = hh_stepped;
                  default: pm_next = pm_reg ^ (i_val_inc_pulse ^ i_val_dec_pulse);
               endcase
            end
         end
         ST_COMMIT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign o_edit  = (state_reg == ST_EDIT) || (state_reg == ST_COMMIT);
   assign o_load  = (state_reg == ST_COMMIT);
   assign o_field = field_reg;
   assign o_pm    = pm_reg;
   assign o_hh    = hh_reg;
   assign o_mm    = mm_reg;
   assign o_ss    = ss_reg;

endmodule
